// File: rtl/pc_fetch_unit_pkg.sv
// Shared constants for the fetch-stage program counter and its return-address stack.
package pc_fetch_unit_pkg;

    localparam int unsigned ADDR_W_DEF   = 16;
    localparam logic [15:0] RESET_PC_DEF = 16'h0000;

    localparam logic [1:0] PC_SRC_SEQ = 2'b00;
    localparam logic [1:0] PC_SRC_JMP = 2'b01;
    localparam logic [1:0] PC_SRC_BR  = 2'b10;
    localparam logic [1:0] PC_SRC_RET = 2'b11;

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack: a push when full overwrites the oldest entry, and a pop
// when empty is ignored.
module return_addr_stack #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_FULL);
    // The pointer names the next free slot, so the top lives one below it.
    assign top   = mem_q[ptr_q - PTR_ONE];

    always_comb begin
        mem_d   = mem_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        if (push) begin
            mem_d[ptr_q] = push_data;
            ptr_d        = ptr_q + PTR_ONE;
            count_d      = full ? count_q : count_q + CNT_ONE;
        end else if (pop && !empty) begin
            ptr_d   = ptr_q - PTR_ONE;
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch-stage PC register and next-PC select, with valid/PC tags that line up with the
// registered output of the synchronous instruction memory.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int unsigned        ADDR_W    = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0]  RESET_PC  = ADDR_W'(RESET_PC_DEF),
    parameter int unsigned        RAS_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              kill,
    input  logic [1:0]        pc_src,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              is_call,
    input  logic [ADDR_W-1:0] ret_addr,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_fetched,
    output logic              fetch_valid,
    output logic              ras_overflow,
    output logic              ras_underflow
);

    localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_fetched_q, pc_fetched_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic              ras_ovf_q, ras_ovf_d;
    logic              ras_udf_q, ras_udf_d;

    logic              ras_push, ras_pop;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_empty, ras_full;
    logic [ADDR_W-1:0] next_pc;

    assign ras_push = (pc_src == PC_SRC_JMP) && is_call && !stall;
    assign ras_pop  = (pc_src == PC_SRC_RET) && !stall;

    return_addr_stack #(
        .DEPTH (RAS_DEPTH),
        .WIDTH (ADDR_W)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (ret_addr),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );

    always_comb begin
        next_pc = pc_q + PC_ONE;
        unique case (pc_src)
            PC_SRC_SEQ: next_pc = pc_q + PC_ONE;
            PC_SRC_JMP: next_pc = jump_target;
            PC_SRC_BR:  next_pc = branch_target;
            PC_SRC_RET: next_pc = ras_empty ? RESET_PC : ras_top;
            default:    next_pc = pc_q + PC_ONE;
        endcase
    end

    always_comb begin
        pc_d          = pc_q;
        pc_fetched_d  = pc_fetched_q;
        fetch_valid_d = fetch_valid_q;
        ras_ovf_d     = ras_ovf_q;
        ras_udf_d     = ras_udf_q;
        // A stall freezes everything, including any redirect presented alongside it.
        if (!stall) begin
            pc_d          = next_pc;
            pc_fetched_d  = pc_q;
            fetch_valid_d = !kill && (pc_src == PC_SRC_SEQ);
            ras_ovf_d     = ras_ovf_q | (ras_push & ras_full);
            ras_udf_d     = ras_udf_q | (ras_pop & ras_empty);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            pc_fetched_q  <= '0;
            fetch_valid_q <= 1'b0;
            ras_ovf_q     <= 1'b0;
            ras_udf_q     <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            pc_fetched_q  <= pc_fetched_d;
            fetch_valid_q <= fetch_valid_d;
            ras_ovf_q     <= ras_ovf_d;
            ras_udf_q     <= ras_udf_d;
        end
    end

    assign pc            = pc_q;
    assign pc_fetched    = pc_fetched_q;
    assign fetch_valid   = fetch_valid_q;
    assign ras_overflow  = ras_ovf_q;
    assign ras_underflow = ras_udf_q;

endmodule
